// File: rtl/rosc_entropy_pkg.sv
// Shared state encoding and width helper for the multi-channel ring-oscillator entropy source.
package rosc_entropy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_e;

    // Never returns less than 1 so single-value counters still get a real bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/rosc_entropy_src_channel.sv
// One adder-feedback oscillator channel: operand adder whose carry-out is registered
// and fed back inverted as carry-in.
module rosc_channel
    import rosc_entropy_pkg::*;
#(
    parameter int OP_WIDTH = 8
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [OP_WIDTH-1:0] opa,
    input  logic [OP_WIDTH-1:0] opb,
    output logic                carry
);

    logic [OP_WIDTH:0] sum;
    logic              carry_q;
    logic              carry_d;

    // The loop closes through carry_q, so the all-ones case toggles once per clk.
    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb} + {{OP_WIDTH{1'b0}}, ~carry_q};
        carry_d = 1'(sum >> OP_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;

endmodule

// File: rtl/rosc_entropy_src.sv
// Multi-channel entropy source: XORs NUM_OSC oscillator channels, samples on a prescaler
// tick and packs bits into words. Define ROSC_ENTROPY_DEBIAS_EN for a von Neumann debiaser.
module rosc_entropy_src
    import rosc_entropy_pkg::*;
#(
    parameter int NUM_OSC       = 16,
    parameter int OP_WIDTH      = 8,
    parameter int WORD_WIDTH    = 32,
    parameter int SAMPLE_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        enable,
    input  logic [NUM_OSC*OP_WIDTH-1:0] opa,
    input  logic [NUM_OSC*OP_WIDTH-1:0] opb,
    input  logic                        ready,
    output logic [WORD_WIDTH-1:0]       data,
    output logic                        valid,
    output logic                        raw_bit
);

    localparam int CNT_W = clog2(WORD_WIDTH + 1);
    localparam int PRE_W = clog2(SAMPLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORD_WIDTH - 1);
    localparam logic [PRE_W-1:0] LAST_PRE   = PRE_W'(SAMPLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [NUM_OSC-1:0]    chan_q;
    logic                  raw_bit_q, raw_bit_d;
    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  collect_tick;
    logic                  shift_en;
    logic                  shift_bit;
    logic                  last_shift;

    for (genvar i = 0; i < NUM_OSC; i++) begin : g_chan
        rosc_channel #(
            .OP_WIDTH (OP_WIDTH)
        ) u_chan (
            .clk    (clk),
            .nreset (nreset),
            .opa    (opa[i*OP_WIDTH +: OP_WIDTH]),
            .opb    (opb[i*OP_WIDTH +: OP_WIDTH]),
            .carry  (chan_q[i])
        );
    end

    always_comb begin
        raw_bit_d    = ^chan_q;
        collect_tick = (state_q == COLLECT) && enable && (prescaler_q == LAST_PRE);
        last_shift   = shift_en && (count_q == LAST_COUNT);
    end

`ifdef ROSC_ENTROPY_DEBIAS_EN
    logic phase_q, phase_d;
    logic hold_q, hold_d;

    // Pair phase only advances while collecting; leaving COLLECT for any reason restarts it.
    always_comb begin
        phase_d   = phase_q;
        hold_d    = hold_q;
        shift_en  = 1'b0;
        shift_bit = hold_q;
        if (collect_tick) begin
            if (!phase_q) begin
                hold_d  = raw_bit_q;
                phase_d = 1'b1;
            end else begin
                phase_d  = 1'b0;
                shift_en = (hold_q != raw_bit_q);
            end
        end
        if ((state_q != COLLECT) || !enable) begin
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            phase_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end
`else
    always_comb begin
        shift_en  = collect_tick;
        shift_bit = raw_bit_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = COLLECT;
            COLLECT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (last_shift) begin
                    state_d = FULL;
                end
            end
            FULL:    if (valid_q && ready) state_d = enable ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A dropped enable in COLLECT discards the partial count but leaves data untouched.
    always_comb begin
        data_d      = data_q;
        count_d     = count_q;
        prescaler_d = '0;
        valid_d     = valid_q;
        case (state_q)
            COLLECT: begin
                if (enable) begin
                    prescaler_d = collect_tick ? '0 : prescaler_q + PRE_W'(1);
                    if (shift_en) begin
                        data_d  = {data_q[WORD_WIDTH-2:0], shift_bit};
                        count_d = count_q + CNT_W'(1);
                    end
                    if (last_shift) begin
                        valid_d     = 1'b1;
                        prescaler_d = '0;
                    end
                end else begin
                    count_d = '0;
                end
            end
            FULL: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    count_d = '0;
                end
            end
            default: begin
                count_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            raw_bit_q   <= 1'b0;
            prescaler_q <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            raw_bit_q   <= raw_bit_d;
            prescaler_q <= prescaler_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign raw_bit = raw_bit_q;

endmodule

// File: tb/tb_rosc_entropy_src.sv
// Directed bench for rosc_entropy_src with 4 channels, 8-bit words and a 4-cycle prescaler;
// expected words are queued as stimulus is applied and popped when valid is observed.
module tb_rosc_entropy_src;

    localparam int NUM_OSC       = 4;
    localparam int OP_WIDTH      = 8;
    localparam int WORD_WIDTH    = 8;
    localparam int SAMPLE_CYCLES = 4;

    localparam logic [31:0] OPA_QUIET = 32'h1010_1010;
    localparam logic [31:0] OPB_QUIET = 32'h1010_1010;
    localparam logic [31:0] OPA_CH0   = 32'h1010_10F0;
    localparam logic [31:0] OPB_CH0   = 32'h1010_1020;
    localparam logic [31:0] OPA_CH01  = 32'h1010_F0F0;
    localparam logic [31:0] OPB_CH01  = 32'h1010_2020;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic        ready;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [7:0]  data;
    logic        valid;
    logic        raw_bit;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    rosc_entropy_src #(
        .NUM_OSC       (NUM_OSC),
        .OP_WIDTH      (OP_WIDTH),
        .WORD_WIDTH    (WORD_WIDTH),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .enable  (enable),
        .opa     (opa),
        .opb     (opb),
        .ready   (ready),
        .data    (data),
        .valid   (valid),
        .raw_bit (raw_bit)
    );

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic en, input logic rdy);
        opa    = a;
        opb    = b;
        enable = en;
        ready  = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Waits for valid within a cycle budget and compares data against the scoreboard head.
    task automatic waitWord(input string tag, input int budget, output int cycles);
        logic [7:0] expected;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid && cycles < budget);
        if (!valid) begin
            checkOutput({tag, "_timeout"}, 32'(valid), 32'd1);
        end else begin
            expected = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checkOutput({tag, "_data"}, 32'(data), 32'(expected));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nreset = 1'b0;
        applyStimulus(OPA_QUIET, OPB_QUIET, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_data", 32'(data), 32'd0);
        checkOutput("reset_raw_bit", 32'(raw_bit), 32'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_valid", 32'(valid), 32'd0);

`ifdef ROSC_ENTROPY_DEBIAS_EN
        // Channel 0 alternates 1,0 per tick so every pair is 10 and shifts a 1.
        exp_q.push_back(8'hFF);
        applyStimulus(OPA_CH0, OPB_CH0, 1'b1, 1'b1);
        @(negedge clk);
        for (int j = 1; j <= 16; j++) begin
            repeat (4) @(negedge clk);
            if (j % 2 == 0) applyStimulus(OPA_CH0, OPB_CH0, 1'b1, 1'b1);
            else            applyStimulus(OPA_QUIET, OPB_QUIET, 1'b1, 1'b1);
        end
        checkOutput("debias_valid", 32'(valid), 32'd1);
        checkOutput("debias_data", 32'(data), 32'(exp_q.pop_front()));
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid) seen++;
        end
        checkOutput("debias_constant_no_valid", 32'(seen), 32'd0);
`else
        exp_q.push_back(8'h00);
        applyStimulus(OPA_QUIET, OPB_QUIET, 1'b1, 1'b1);
        waitWord("zero_first", 100, lat);
        checkOutput("zero_first_latency", 32'(lat), 32'd33);

        exp_q.push_back(8'h00);
        waitWord("zero_repeat", 100, lat);
        checkOutput("zero_repeat_period", 32'(lat), 32'd33);

        exp_q.push_back(8'hFF);
        applyStimulus(OPA_CH0, OPB_CH0, 1'b1, 1'b1);
        waitWord("ch0_word", 100, lat);
        checkOutput("ch0_period", 32'(lat), 32'd33);

        exp_q.push_back(8'h00);
        applyStimulus(OPA_CH01, OPB_CH01, 1'b1, 1'b1);
        waitWord("ch01_word", 100, lat);

        // Backpressure: hold the word while operands would now produce zeros.
        applyStimulus(OPA_CH0, OPB_CH0, 1'b1, 1'b1);
        @(negedge clk);
        ready = 1'b0;
        exp_q.push_back(8'hFF);
        waitWord("hold_word", 100, lat);
        checkOutput("hold_latency", 32'(lat), 32'd32);
        applyStimulus(OPA_QUIET, OPB_QUIET, 1'b1, 1'b0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid !== 1'b1 || data !== 8'hFF) seen++;
        end
        checkOutput("hold_stable", 32'(seen), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        checkOutput("release_valid_low", 32'(valid), 32'd0);
        exp_q.push_back(8'h00);
        waitWord("after_release", 100, lat);
        checkOutput("after_release_latency", 32'(lat), 32'd32);

        // Drop enable after three ticks; the partial word must be discarded.
        repeat (13) @(negedge clk);
        applyStimulus(OPA_CH0, OPB_CH0, 1'b0, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) seen++;
        end
        checkOutput("disabled_no_valid", 32'(seen), 32'd0);
        exp_q.push_back(8'hFF);
        applyStimulus(OPA_CH0, OPB_CH0, 1'b1, 1'b0);
        waitWord("reenable", 100, lat);
        checkOutput("reenable_latency", 32'(lat), 32'd33);

        // Reset while holding a full word.
        nreset = 1'b0;
        @(negedge clk);
        checkOutput("full_reset_valid", 32'(valid), 32'd0);
        checkOutput("full_reset_data", 32'(data), 32'd0);
        checkOutput("full_reset_raw_bit", 32'(raw_bit), 32'd0);
        nreset = 1'b1;
        ready  = 1'b1;
        exp_q.push_back(8'hFF);
        waitWord("post_reset", 100, lat);
        checkOutput("post_reset_latency", 32'(lat), 32'd33);
`endif

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
